// File: rtl/udcount_bcd_n.sv
// udcount_bcd_n -- N-digit cascaded BCD up/down counter
//
// Purpose:
//   Counts up or down in BCD across DIGITS cascaded decade digits. The most
//   significant digit is limited to MAX_MSD, so a counter with DIGITS=2 and
//   MAX_MSD=5 counts modulo 60. Provides a synchronous clear, a parallel load
//   (clamped to legal BCD), a registered wrap pulse and a combinational
//   terminal-count flag for chaining.
//
// Parameters:
//   DIGITS   number of BCD digits (1..8), digit 0 least significant
//   MAX_MSD  largest value of the most significant digit (1..9)
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-low reset (q=0, carry=0)
//   enable  in   count enable
//   ud      in   direction: 0 = up, 1 = down
//   clear   in   synchronous clear (highest priority)
//   load    in   synchronous parallel load of din
//   din     in   load value, digit i at din[4i+3:4i]
//   q       out  count value, digit i at q[4i+3:4i]
//   carry   out  one-cycle pulse on wrap (or on a blocked step when saturating)
//   tc      out  enable & (at MAXV counting up, or at zero counting down)
//
// Build option:
//   UDCNT_SATURATE_EN  when defined, the counter holds at MAXV (up) or zero
//                      (down) instead of wrapping; carry pulses on each
//                      enabled edge spent at the held limit.

module udcount_bcd_n #(
    parameter int DIGITS  = 4,
    parameter int MAX_MSD = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ud,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  carry,
    output logic                  tc
);

    localparam int unsigned ND      = $unsigned(DIGITS);
    localparam logic [3:0]  MSD_TOP = 4'(MAX_MSD);

    logic [4*DIGITS-1:0] q_cnt;
    logic [4*DIGITS-1:0] q_ld;
    logic                all_top;
    logic                all_zero;
    logic                chain;
    logic                at_limit;
    logic [3:0]          d;
    logic [3:0]          d_in;
    logic [3:0]          lim;

    // Ripple the step condition upward: a digit steps only while every lower
    // digit sits at its roll-over value for the current direction.
    always_comb begin
        q_cnt    = q;
        q_ld     = '0;
        all_top  = 1'b1;
        all_zero = 1'b1;
        chain    = 1'b1;
        d        = '0;
        d_in     = '0;
        lim      = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            d    = q[4*i +: 4];
            d_in = din[4*i +: 4];
            lim  = (i == ND - 1) ? MSD_TOP : 4'd9;

            q_ld[4*i +: 4] = (d_in > lim) ? lim : d_in;

            if (chain) begin
                if (!ud)
                    q_cnt[4*i +: 4] = (d == lim) ? 4'd0 : d + 4'd1;
                else
                    q_cnt[4*i +: 4] = (d == 4'd0) ? lim : d - 4'd1;
            end

            chain    = chain & (ud ? (d == 4'd0) : (d == lim));
            all_top  = all_top & (d == lim);
            all_zero = all_zero & (d == 4'd0);
        end
    end

    assign at_limit = ud ? all_zero : all_top;
    assign tc       = enable & at_limit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q     <= '0;
            carry <= 1'b0;
        end else if (clear) begin
            q     <= '0;
            carry <= 1'b0;
        end else if (load) begin
            q     <= q_ld;
            carry <= 1'b0;
        end else if (enable) begin
`ifdef UDCNT_SATURATE_EN
            if (at_limit) begin
                q     <= q;
                carry <= 1'b1;
            end else begin
                q     <= q_cnt;
                carry <= 1'b0;
            end
`else
            q     <= q_cnt;
            carry <= at_limit;
`endif
        end else begin
            carry <= 1'b0;
        end
    end

endmodule

// File: tb/tb_udcount_bcd_n.sv
// Directed self-checking bench for udcount_bcd_n.
// dut_a: DIGITS=2, MAX_MSD=5 (mod 60); dut_b: DIGITS=4, MAX_MSD=9.

module tb_udcount_bcd_n;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        enable_a = 1'b0, ud_a = 1'b0, clear_a = 1'b0, load_a = 1'b0;
    logic [7:0]  din_a = '0;
    logic [7:0]  q_a;
    logic        carry_a, tc_a;

    logic        enable_b = 1'b0, ud_b = 1'b0, clear_b = 1'b0, load_b = 1'b0;
    logic [15:0] din_b = '0;
    logic [15:0] q_b;
    logic        carry_b, tc_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    udcount_bcd_n #(.DIGITS(2), .MAX_MSD(5)) dut_a (
        .clock(clock), .reset(reset), .enable(enable_a), .ud(ud_a),
        .clear(clear_a), .load(load_a), .din(din_a),
        .q(q_a), .carry(carry_a), .tc(tc_a)
    );

    udcount_bcd_n #(.DIGITS(4), .MAX_MSD(9)) dut_b (
        .clock(clock), .reset(reset), .enable(enable_b), .ud(ud_b),
        .clear(clear_b), .load(load_b), .din(din_b),
        .q(q_b), .carry(carry_b), .tc(tc_b)
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_tests++; if (q_a !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want %h", q_a, 8'h00); end
        n_tests++; if (carry_a !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want %b", carry_a, 1'b0); end
        tick();
        reset = 1'b1;
        load_a = 1'b1; din_a = 8'h36;
        tick();
        load_a = 1'b0; enable_a = 1'b1; ud_a = 1'b0;
        tick();
        n_tests++; if (q_a !== 8'h37) begin n_fail++; $display("FAIL midcount_q: got %h want %h", q_a, 8'h37); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (q_a !== 8'h00) begin n_fail++; $display("FAIL async_reset_q: got %h want %h", q_a, 8'h00); end
        n_tests++; if (carry_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_carry: got %b want %b", carry_a, 1'b0); end
        enable_a = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        n_tests++; if (q_a !== 8'h00) begin n_fail++; $display("FAIL hold_after_reset: got %h want %h", q_a, 8'h00); end
    endtask

    task automatic test_wrap_up();
        load_a = 1'b1; din_a = 8'h58; enable_a = 1'b1; ud_a = 1'b0;
        tick();
        load_a = 1'b0;
        n_tests++; if (q_a !== 8'h58) begin n_fail++; $display("FAIL load58: got %h want %h", q_a, 8'h58); end
        tick();
        n_tests++; if (q_a !== 8'h59 || carry_a !== 1'b0) begin n_fail++; $display("FAIL up_59: got q=%h c=%b want q=59 c=0", q_a, carry_a); end
        n_tests++; if (tc_a !== 1'b1) begin n_fail++; $display("FAIL tc_up_max: got %b want %b", tc_a, 1'b1); end
        tick();
        n_tests++; if (q_a !== 8'h00 || carry_a !== 1'b1) begin n_fail++; $display("FAIL up_wrap: got q=%h c=%b want q=00 c=1", q_a, carry_a); end
        n_tests++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL tc_up_zero: got %b want %b", tc_a, 1'b0); end
        tick();
        n_tests++; if (q_a !== 8'h01 || carry_a !== 1'b0) begin n_fail++; $display("FAIL up_after_wrap: got q=%h c=%b want q=01 c=0", q_a, carry_a); end
        tick();
        n_tests++; if (q_a !== 8'h02) begin n_fail++; $display("FAIL up_02: got %h want %h", q_a, 8'h02); end
    endtask

    task automatic test_wrap_down();
        load_a = 1'b1; din_a = 8'h01; ud_a = 1'b1;
        tick();
        load_a = 1'b0;
        n_tests++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL tc_dn_01: got %b want %b", tc_a, 1'b0); end
        tick();
        n_tests++; if (q_a !== 8'h00 || carry_a !== 1'b0) begin n_fail++; $display("FAIL dn_00: got q=%h c=%b want q=00 c=0", q_a, carry_a); end
        n_tests++; if (tc_a !== 1'b1) begin n_fail++; $display("FAIL tc_dn_zero: got %b want %b", tc_a, 1'b1); end
        ud_a = 1'b0; #1;
        n_tests++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL tc_zero_up: got %b want %b", tc_a, 1'b0); end
        ud_a = 1'b1; enable_a = 1'b0; #1;
        n_tests++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL tc_disabled: got %b want %b", tc_a, 1'b0); end
        enable_a = 1'b1;
        tick();
        n_tests++; if (q_a !== 8'h59 || carry_a !== 1'b1) begin n_fail++; $display("FAIL dn_wrap: got q=%h c=%b want q=59 c=1", q_a, carry_a); end
        tick();
        n_tests++; if (q_a !== 8'h58 || carry_a !== 1'b0) begin n_fail++; $display("FAIL dn_58: got q=%h c=%b want q=58 c=0", q_a, carry_a); end
        load_a = 1'b1; din_a = 8'h20;
        tick();
        load_a = 1'b0;
        tick();
        n_tests++; if (q_a !== 8'h19) begin n_fail++; $display("FAIL dn_borrow: got %h want %h", q_a, 8'h19); end
    endtask

    task automatic test_hold();
        enable_a = 1'b0;
        tick();
        tick();
        n_tests++; if (q_a !== 8'h19 || carry_a !== 1'b0) begin n_fail++; $display("FAIL hold: got q=%h c=%b want q=19 c=0", q_a, carry_a); end
    endtask

    task automatic test_load_clear();
        load_a = 1'b1; din_a = 8'hFC;
        tick();
        n_tests++; if (q_a !== 8'h59) begin n_fail++; $display("FAIL clamp_FC: got %h want %h", q_a, 8'h59); end
        din_a = 8'hA3;
        tick();
        n_tests++; if (q_a !== 8'h53) begin n_fail++; $display("FAIL clamp_A3: got %h want %h", q_a, 8'h53); end
        din_a = 8'h4B;
        tick();
        n_tests++; if (q_a !== 8'h49) begin n_fail++; $display("FAIL clamp_4B: got %h want %h", q_a, 8'h49); end
        clear_a = 1'b1; din_a = 8'h12;
        tick();
        n_tests++; if (q_a !== 8'h00) begin n_fail++; $display("FAIL clear_over_load: got %h want %h", q_a, 8'h00); end
        clear_a = 1'b0; din_a = 8'h59; enable_a = 1'b1; ud_a = 1'b0;
        tick();
        load_a = 1'b0; clear_a = 1'b1;
        tick();
        n_tests++; if (q_a !== 8'h00 || carry_a !== 1'b0) begin n_fail++; $display("FAIL clear_over_wrap: got q=%h c=%b want q=00 c=0", q_a, carry_a); end
        clear_a = 1'b0;
        load_a = 1'b1; din_a = 8'h59;
        tick();
        n_tests++; if (q_a !== 8'h59 || carry_a !== 1'b0) begin n_fail++; $display("FAIL load_over_enable: got q=%h c=%b want q=59 c=0", q_a, carry_a); end
        load_a = 1'b0; enable_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        load_a = 1'b1; din_a = 8'h19; enable_a = 1'b1; ud_a = 1'b0;
        tick();
        load_a = 1'b0;
        tick();
        n_tests++; if (q_a !== 8'h20) begin n_fail++; $display("FAIL b2b_up: got %h want %h", q_a, 8'h20); end
        ud_a = 1'b1;
        tick();
        n_tests++; if (q_a !== 8'h19 || carry_a !== 1'b0) begin n_fail++; $display("FAIL b2b_dn: got q=%h c=%b want q=19 c=0", q_a, carry_a); end
        ud_a = 1'b0;
        tick();
        n_tests++; if (q_a !== 8'h20) begin n_fail++; $display("FAIL b2b_up2: got %h want %h", q_a, 8'h20); end
        enable_a = 1'b0;
    endtask

    task automatic test_cascade();
        load_b = 1'b1; din_b = 16'h0999; enable_b = 1'b1; ud_b = 1'b0;
        tick();
        load_b = 1'b0;
        tick();
        n_tests++; if (q_b !== 16'h1000 || carry_b !== 1'b0) begin n_fail++; $display("FAIL b_up_1000: got q=%h c=%b want q=1000 c=0", q_b, carry_b); end
        ud_b = 1'b1;
        tick();
        n_tests++; if (q_b !== 16'h0999) begin n_fail++; $display("FAIL b_dn_0999: got %h want %h", q_b, 16'h0999); end
        load_b = 1'b1; din_b = 16'h9999; ud_b = 1'b0;
        tick();
        load_b = 1'b0;
        n_tests++; if (tc_b !== 1'b1) begin n_fail++; $display("FAIL b_tc_max: got %b want %b", tc_b, 1'b1); end
        tick();
`ifdef UDCNT_SATURATE_EN
        n_tests++; if (q_b !== 16'h9999 || carry_b !== 1'b1) begin n_fail++; $display("FAIL b_sat_max: got q=%h c=%b want q=9999 c=1", q_b, carry_b); end
`else
        n_tests++; if (q_b !== 16'h0000 || carry_b !== 1'b1) begin n_fail++; $display("FAIL b_wrap: got q=%h c=%b want q=0000 c=1", q_b, carry_b); end
`endif
        enable_b = 1'b0;
    endtask

    task automatic test_saturate();
        load_a = 1'b1; din_a = 8'h59; enable_a = 1'b1; ud_a = 1'b0;
        tick();
        load_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (q_a !== 8'h59 || carry_a !== 1'b1) begin n_fail++; $display("FAIL sat_up_%0d: got q=%h c=%b want q=59 c=1", k, q_a, carry_a); end
        end
        ud_a = 1'b1;
        tick();
        n_tests++; if (q_a !== 8'h58 || carry_a !== 1'b0) begin n_fail++; $display("FAIL sat_release: got q=%h c=%b want q=58 c=0", q_a, carry_a); end
        load_a = 1'b1; din_a = 8'h00;
        tick();
        load_a = 1'b0;
        tick();
        n_tests++; if (q_a !== 8'h00 || carry_a !== 1'b1) begin n_fail++; $display("FAIL sat_dn: got q=%h c=%b want q=00 c=1", q_a, carry_a); end
        enable_a = 1'b0;
        tick();
        n_tests++; if (carry_a !== 1'b0) begin n_fail++; $display("FAIL sat_carry_drop: got %b want %b", carry_a, 1'b0); end
    endtask

    initial begin
        test_reset();
`ifdef UDCNT_SATURATE_EN
        test_saturate();
`else
        test_wrap_up();
        test_wrap_down();
`endif
        test_hold();
        test_load_clear();
        test_back_to_back();
        test_cascade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
